// File: rtl/rc_div_32_seq.sv
// rc_div_32_seq: 32-bit unsigned restoring divider, one quotient bit per clock.
// Rev 1.0 - initial release.
`default_nettype none

module rc_add_sub_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SnA,
  output logic [31:0] Y,
  output logic        Cout
);
  logic [32:0] w_c;
  logic [31:0] w_b;

  assign w_c[0] = SnA;
  assign w_b    = B ^ {32{SnA}};

  generate
    for (genvar i = 0; i < 32; i++) begin : g_bit
      assign Y[i]     = A[i] ^ w_b[i] ^ w_c[i];
      assign w_c[i+1] = (A[i] & w_b[i]) | (A[i] & w_c[i]) | (w_b[i] & w_c[i]);
    end
  endgenerate

  assign Cout = w_c[32];
endmodule

module rc_div_32_seq (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        START,
  input  logic [31:0] DIVIDEND,
  input  logic [31:0] DIVISOR,
  output logic [31:0] QUOT,
  output logic [31:0] REM,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIV_BY_ZERO
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] div_q;
  logic [4:0]  cnt_q;

  logic [32:0] shift_d;
  logic [31:0] diff_d;
  logic        cout_d;
  logic        sub_d;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  assign shift_d = {rem_q, quo_q[31]};

  rc_add_sub_32 u_addsub (
    .A    (shift_d[31:0]),
    .B    (div_q),
    .SnA  (1'b1),
    .Y    (diff_d),
    .Cout (cout_d)
  );

  // A set bit 32 means the shifted remainder already exceeds any 32-bit divisor.
  assign sub_d = shift_d[32] | cout_d;
  assign rem_d = sub_d ? diff_d : shift_d[31:0];
  assign quo_d = {quo_q[30:0], sub_d};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      QUOT        <= '0;
      REM         <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            if (DIVISOR != 32'd0) begin
              rem_q       <= '0;
              quo_q       <= DIVIDEND;
              div_q       <= DIVISOR;
              cnt_q       <= '0;
              DIV_BY_ZERO <= 1'b0;
              BUSY        <= 1'b1;
              state_q     <= CALC;
            end else begin
              QUOT        <= 32'hFFFF_FFFF;
              REM         <= DIVIDEND;
              DIV_BY_ZERO <= 1'b1;
              DONE        <= 1'b1;
              state_q     <= FIN;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            QUOT    <= quo_d;
            REM     <= rem_d;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_rc_div_32_seq.sv
// Self-checking bench for rc_div_32_seq: scoreboard of expected results against a division model.
`default_nettype none

module tb_rc_div_32_seq;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DIVIDEND = '0;
  logic [31:0] DIVISOR = '0;
  logic [31:0] QUOT, REM;
  logic        BUSY, DONE, DIV_BY_ZERO;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  rc_div_32_seq dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .START       (START),
    .DIVIDEND    (DIVIDEND),
    .DIVISOR     (DIVISOR),
    .QUOT        (QUOT),
    .REM         (REM),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Result scoreboard: every DONE pops one expected entry.
  always @(negedge CLK) begin
    if (RSTn && DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", QUOT, e.q);
        chk("rem", REM, e.r);
        chk("div_by_zero", {31'd0, DIV_BY_ZERO}, {31'd0, e.dbz});
      end
    end
  end

  // glitch_at/abort_at: CALC cycle index for a stray START or a reset (0 = none).
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input int glitch_at, input int abort_at);
    exp_t e;
    int   n;
    int   busy_n;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0);
    sb.push_back(e);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;
    DIVIDEND = $urandom;
    DIVISOR  = $urandom;
    n = 1;
    busy_n = 0;
    while (!DONE && n < 100) begin
      if (BUSY) busy_n++;
      if (n == 2 && b != 0) begin
        chk("quot_hold", QUOT, prev_q);
        chk("rem_hold", REM, prev_r);
      end
      if (glitch_at != 0 && n == glitch_at) begin
        START = 1'b1; DIVIDEND = 32'd55; DIVISOR = 32'd3;
      end else begin
        START = 1'b0;
      end
      if (abort_at != 0 && n == abort_at) begin
        RSTn = 1'b0;
        #1;
        chk("abort_quot", QUOT, 32'd0);
        chk("abort_rem", REM, 32'd0);
        chk("abort_flags", {29'd0, BUSY, DONE, DIV_BY_ZERO}, 32'd0);
        void'(sb.pop_back());
        @(negedge CLK);
        RSTn = 1'b1;
        prev_q = '0;
        prev_r = '0;
        repeat (40) @(negedge CLK);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        return;
      end
      @(negedge CLK);
      n++;
    end
    chk("latency", n, (b == 0) ? 32'd1 : 32'd33);
    chk("busy_cycles", busy_n, (b == 0) ? 32'd0 : 32'd32);
    @(negedge CLK);
    chk("done_pulse", {31'd0, DONE}, 32'd0);
    prev_q = e.q;
    prev_r = e.r;
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge CLK);
    chk("rst_quot", QUOT, 32'd0);
    chk("rst_rem", REM, 32'd0);
    chk("rst_flags", {29'd0, BUSY, DONE, DIV_BY_ZERO}, 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    run(32'd100, 32'd7, 0, 0);
    run(32'hFFFF_FFFF, 32'h8000_0001, 0, 0);
    run(32'hFFFF_FFFF, 32'd1, 0, 0);
    run(32'd3, 32'd10, 0, 0);
    run(32'd0, 32'd5, 0, 0);
    run(32'd5, 32'd0, 0, 0);
    run(32'd9, 32'd3, 0, 0);
    run(32'd1000, 32'd13, 10, 0);
    run(32'd12345, 32'd77, 0, 15);
    run(32'd100, 32'd7, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case (i % 8)
        0: b = 32'd1;
        1: b = 32'hFFFF_FFFF;
        2: b = a;
        3: b = $urandom_range(15, 1);
        4: b = $urandom & 32'h0000_FFFF;
        default: b = $urandom;
      endcase
      if (i % 50 == 7) b = 32'd0;
      run(a, b, 0, 0);
    end

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
